// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: MEM stage has priority, a starved debug
// requester is forced through after MAX_WAIT blocked cycles.
module dmem_port_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_spo
);

    localparam logic [3:0] MAXW = 4'(MAX_WAIT);

    typedef enum logic {
        IDLE,
        ACK
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              dbg_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wait_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        wait_d  = wait_q;
        rdata_d = rdata_q;
        if (state_q == IDLE && dbg_grant) begin
            state_d = ACK;
        end
        // Age only counts cycles the CPU actually blocked a pending request.
        if (!dbg_req || dbg_grant) begin
            wait_d = '0;
        end else if (state_q == IDLE && cpu_req && wait_q != MAXW) begin
            wait_d = wait_q + 4'd1;
        end
        if (dbg_grant && !dbg_we) begin
            rdata_d = mem_spo;
        end
    end

    always_comb begin
        dbg_grant = (state_q == IDLE) && dbg_req
                    && (!cpu_req || wait_q == MAXW);
        cpu_stall = cpu_req && dbg_grant;
        cpu_rdata = mem_spo;
        dbg_ack   = (state_q == ACK);
        dbg_rdata = rdata_q;
        if (dbg_grant) begin
            mem_a  = dbg_addr;
            mem_d  = dbg_wdata;
            mem_we = dbg_we;
        end else begin
            mem_a  = cpu_addr;
            mem_d  = cpu_wdata;
            mem_we = cpu_we && cpu_req;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter with a behavioural data memory
// and a reference model of grants, stalls and memory contents.
module tb_dmem_port_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          dbg_req = 1'b0, dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d;
    logic          mem_we;
    logic [DW-1:0] mem_spo;

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_spo(mem_spo)
    );

    always #5 clk = ~clk;

    // behavioural data_mem
    logic [DW-1:0] mem [2**AW];
    assign mem_spo = mem[mem_a];
    always @(posedge clk) if (mem_we) mem[mem_a] <= mem_d;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    int n_ack = 0;

    task automatic check(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // reference model state
    typedef struct {
        int            c;
        logic [DW-1:0] d;
    } exp_t;
    exp_t          sb[$];
    logic [DW-1:0] refm [2**AW];
    int            age;
    bit            in_ack;
    logic [DW-1:0] last_rd;
    bit            saw_ack, saw_stall;
    bit            m_stall;

    task automatic model_reset();
        sb.delete();
        age = 0;
        in_ack = 0;
        last_rd = '0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (dbg_ack) begin
                n_ack++;
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    check("ack_cycle", DW'(cyc), DW'(sb[0].c));
                    check("dbg_rdata", dbg_rdata, sb[0].d);
                    void'(sb.pop_front());
                end
            end else if (sb.size() != 0 && sb[0].c <= cyc) begin
                check("missing_ack", 32'd0, 32'd1);
                void'(sb.pop_front());
            end
        end
    end

    // one clock of stimulus: predict, check combinational port, advance model
    task automatic tick();
        bit g;
        g = dbg_req && !in_ack && (!cpu_req || age >= MW);
        m_stall = cpu_req && g;
        @(negedge clk);
        check("cpu_stall", DW'(cpu_stall), DW'(m_stall));
        check("mem_we", DW'(mem_we), DW'(g ? dbg_we : cpu_we && cpu_req));
        check("mem_a", DW'(mem_a), DW'(g ? dbg_addr : cpu_addr));
        if (mem_we) check("mem_d", mem_d, g ? dbg_wdata : cpu_wdata);
        saw_ack = dbg_ack;
        saw_stall = cpu_stall;
        if (g) begin
            if (dbg_we) refm[dbg_addr] = dbg_wdata;
            else last_rd = refm[dbg_addr];
            sb.push_back('{cyc + 1, last_rd});
        end else if (cpu_req && cpu_we) begin
            refm[cpu_addr] = cpu_wdata;
        end
        if (!dbg_req || g) age = 0;
        else if (cpu_req && !in_ack && age < MW) age++;
        in_ack = g;
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_set(bit we, int a, logic [DW-1:0] d);
        dbg_req = 1'b1;
        dbg_we = we;
        dbg_addr = AW'(a);
        dbg_wdata = d;
    endtask

    task automatic cpu_set(bit r, bit we, int a, logic [DW-1:0] d);
        cpu_req = r;
        cpu_we = we;
        cpu_addr = AW'(a);
        cpu_wdata = d;
    endtask

    task automatic flush();
        dbg_req = 1'b0;
        cpu_set(0, 0, 0, 0);
        repeat (3) tick();
    endtask

    initial begin
        int first_stall, k, a0, bad;
        for (int i = 0; i < 2**AW; i++) begin
            mem[i] = 32'hA5000000 ^ (i * 32'h01010101);
            refm[i] = mem[i];
        end
        model_reset();

        // reset state with both sides requesting
        cpu_set(1, 0, 9, 0);
        dbg_set(0, 20, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", DW'(dbg_ack), 0);
        check("rst_rdata", dbg_rdata, 0);
        check("rst_stall", DW'(cpu_stall), 0);
        check("rst_mem_a", DW'(mem_a), 9);
        dbg_req = 1'b0;
        cpu_req = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // idle CPU: write then read back addr 5
        dbg_set(1, 5, 32'hDEADBEEF);
        tick();
        tick();
        check("wr_ack_cycle2", DW'(saw_ack), 1);
        dbg_req = 1'b0;
        tick();
        dbg_set(0, 5, 0);
        tick();
        tick();
        dbg_req = 1'b0;
        tick();
        check("rd_back", dbg_rdata, 32'hDEADBEEF);

        // CPU priority for MAX_WAIT cycles
        dbg_set(0, 11, 0);
        cpu_set(1, 1, 3, 32'h12345678);
        for (int i = 0; i < MW; i++) begin
            tick();
            check("prio_no_stall", DW'(saw_stall), 0);
        end
        check("cpu_store", mem[3], 32'h12345678);
        cpu_req = 1'b0;
        tick();
        tick();
        flush();

        // starvation: forced grant on cycle MAX_WAIT+1
        first_stall = 0;
        dbg_set(0, 3, 0);
        cpu_set(1, 0, 40, 0);
        for (int i = 1; i <= MW + 3; i++) begin
            tick();
            if (saw_stall && first_stall == 0) first_stall = i;
            if (i == MW + 2) begin
                check("starve_retry_nostall", DW'(saw_stall), 0);
                check("starve_ack", DW'(saw_ack), 1);
                dbg_req = 1'b0;
            end
        end
        check("starve_stall_cycle", DW'(first_stall), DW'(MW + 1));
        flush();

        // held request: two grants at cycles 1 and 3
        k = n_ack;
        dbg_set(0, 17, 0);
        cpu_set(0, 0, 33, 0);
        repeat (4) tick();
        dbg_req = 1'b0;
        repeat (3) tick();
        check("held_two_grants", DW'(n_ack - k), 2);

        // reset during ACK drops the ack, request is re-served
        dbg_set(0, 7, 0);
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_ack_drop", DW'(dbg_ack), 0);
        check("midrst_rdata", dbg_rdata, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        k = n_ack;
        tick();
        tick();
        dbg_req = 1'b0;
        tick();
        check("midrst_reserved", DW'(n_ack - k), 1);
        check("midrst_rd", dbg_rdata, refm[7]);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (!saw_stall) begin
                a0 = int'($urandom_range(0, 2**AW - 1));
                cpu_set($urandom_range(0, 9) < 6, $urandom_range(0, 2) == 0,
                        a0, $urandom);
            end
            if (dbg_req && saw_ack) dbg_req = 1'b0;
            if (!dbg_req && $urandom_range(0, 2) == 0) begin
                dbg_set($urandom_range(0, 1) == 1,
                        int'($urandom_range(0, 2**AW - 1)), $urandom);
            end
            tick();
        end
        flush();
        check("sb_drained", DW'(sb.size()), 0);

        bad = 0;
        for (int i = 0; i < 2**AW; i++) if (mem[i] !== refm[i]) bad++;
        check("mem_image", DW'(bad), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
